// File: rtl/usb_crc_serializer.sv
// Serialises a USB token/data payload LSB-first and appends its complemented CRC5/CRC16.
// Optional feature: define USB_CRC_SERIALIZER_CRCQ_EN to add the crc_q result port.
module usb_crc_serializer #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  input  logic                mode,
  input  logic [LEN_W-1:0]    len,
  input  logic [MAX_BITS-1:0] data,
  output logic                ready,
  output logic                bit_out,
  output logic                bit_valid,
  input  logic                out_ready,
  output logic                done
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
  ,
  output logic [15:0]         crc_q
`endif
);

  localparam int IDX_W = $clog2(MAX_BITS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] data_reg;
  logic [LEN_W-1:0]    len_reg;
  logic                mode_reg;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          k;
  logic [15:0]         crc_reg;

  logic             accept, consume, last_data, last_crc;
  logic [LEN_W-1:0] len_clamped;

  // One shift of the serial CRC; CRC5 lives in the low five bits.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic m, input logic b);
    logic fb;
    if (m) begin
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end else begin
      fb = c[4] ^ b;
      return {11'b0, {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000)};
    end
  endfunction

  assign ready       = (state_q == S_IDLE);
  assign bit_valid   = (state_q == S_DATA) || (state_q == S_CRC);
  assign done        = (state_q == S_DONE);
  assign accept      = ready && start;
  assign consume     = bit_valid && out_ready;
  assign len_clamped = (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
  assign last_data   = (LEN_W'(idx) == len_reg - LEN_W'(1));
  assign last_crc    = (k == 4'd0);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    bit_out = 1'b0;
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (len_clamped == '0) ? S_CRC : S_DATA;
      S_DATA: begin
        bit_out = data_reg[idx];
        if (out_ready && last_data) state_d = S_CRC;
      end
      S_CRC: begin
        bit_out = ~crc_reg[k];
        if (out_ready && last_crc) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      len_reg  <= '0;
      mode_reg <= 1'b0;
      idx      <= '0;
      k        <= 4'd0;
      crc_reg  <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_reg  <= len_clamped;
        mode_reg <= mode;
        idx      <= '0;
        k        <= mode ? 4'd15 : 4'd4;
        crc_reg  <= mode ? 16'hFFFF : 16'h001F;
      end else if (consume && state_q == S_DATA) begin
        crc_reg <= crc_step(crc_reg, mode_reg, bit_out);
        idx     <= idx + IDX_W'(1);
      end else if (consume && state_q == S_CRC) begin
        k <= k - 4'd1;
      end
    end
  end

  // NOTE: the payload buffer is deliberately not reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (accept) data_reg <= data;
  end

`ifdef USB_CRC_SERIALIZER_CRCQ_EN
  // Captured as the last CRC bit leaves, so it is already valid during DONE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      crc_q <= 16'h0000;
    end else if (consume && state_q == S_CRC && last_crc) begin
      crc_q <= mode_reg ? ~crc_reg : {11'b0, ~crc_reg[4:0]};
    end
  end
`endif

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Self-checking bench for usb_crc_serializer against an arithmetic CRC reference model.
// Define USB_CRC_SERIALIZER_CRCQ_EN to also check the crc_q port.
module tb_usb_crc_serializer;

  localparam int MAX_BITS = 64;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic                clk = 1'b0;
  logic                rst_b = 1'b0;
  logic                start = 1'b0;
  logic                mode = 1'b0;
  logic [LEN_W-1:0]    len = '0;
  logic [MAX_BITS-1:0] data = '0;
  logic                out_ready = 1'b1;
  logic                ready, bit_out, bit_valid, done;
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
  logic [15:0]         crc_q;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];
  bit got_q[$];
  bit ref_q[$];
  int unsigned exp_crc;

  always #5 clk = ~clk;

  usb_crc_serializer #(.MAX_BITS(MAX_BITS)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .mode(mode), .len(len), .data(data),
    .ready(ready), .bit_out(bit_out), .bit_valid(bit_valid), .out_ready(out_ready),
    .done(done)
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
    , .crc_q(crc_q)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp, emit payload LSB first, then complemented CRC MSB first.
  task automatic build_expected(input logic m, input int unsigned l, input logic [63:0] d);
    int unsigned n    = (l > MAX_BITS) ? MAX_BITS : l;
    int unsigned w    = m ? 16 : 5;
    int unsigned poly = m ? 32'h8005 : 32'h5;
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned crc  = mask;
    int unsigned fb;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(d[i]);
      fb  = ((crc >> (w - 1)) & 1) ^ int'(d[i]);
      crc = ((crc << 1) & mask) ^ (fb != 0 ? poly : 0);
    end
    exp_crc = ~crc & mask;
    for (int j = int'(w) - 1; j >= 0; j--) exp_q.push_back(((exp_crc >> j) & 1) != 0);
  endtask

  task automatic send(input string tag, input logic m, input int unsigned l,
                      input logic [63:0] d, input bit stall, input bit busy);
    bit prev_stall = 0;
    bit prev_bit   = 0;
    int last_cyc   = -1;
    int done_cyc   = -1;
    build_expected(m, l, d);
    got_q.delete();
    @(negedge clk);
    check({tag, "_ready_pre"}, ready, 1);
    start = 1'b1; mode = m; len = LEN_W'(l); data = d;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_latency"}, bit_valid, 1);
    for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy) begin
        start = (cyc == 3);
        data  = ~d;
        mode  = ~m;
      end
      if (prev_stall) check({tag, "_stall_hold"}, {bit_valid, bit_out}, {1'b1, prev_bit});
      if (done) begin
        done_cyc = cyc;
        check({tag, "_done_flags"}, {bit_valid, ready}, 2'b00);
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bit_valid && out_ready) begin
        got_q.push_back(bit_out);
        last_cyc = cyc;
      end
      prev_stall = bit_valid && !out_ready;
      prev_bit   = bit_out;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, done_cyc >= 0, 1);
    check({tag, "_done_timing"}, done_cyc, last_cyc + 1);
    check({tag, "_nbits"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check({tag, "_idle_after"}, {ready, bit_valid, done}, 3'b100);
    end
  endtask

  initial begin
    int cnt;
    bit nostall_q[$];

    // Reset state
    #2;
    check("rst_outputs", {ready, bit_valid, bit_out, done}, 4'b1000);
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
    check("rst_crc_q", crc_q, 0);
`endif
    @(negedge clk); rst_b = 1'b1;

    // Token packet
    send("token", 1'b0, 11, 64'd0, 0, 0);
    check("token_crc_bits", {got_q[11], got_q[12], got_q[13], got_q[14], got_q[15]}, 5'b01000);
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
    check("token_crc_q", crc_q, 16'h0008);
`endif

    // Empty data packet
    send("empty", 1'b1, 0, 64'd0, 0, 0);

    // Stall versus free-running
    send("a5_free", 1'b1, 8, 64'hA5, 0, 0);
    nostall_q = got_q;
    send("a5_stall", 1'b1, 8, 64'hA5, 1, 0);
    check("a5_same_len", got_q.size(), nostall_q.size());
    for (int i = 0; i < got_q.size() && i < nostall_q.size(); i++)
      check($sformatf("a5_same_bit%0d", i), got_q[i], nostall_q[i]);

    // Busy start is ignored
    send("busy", 1'b0, 11, 64'h5A3, 0, 1);

    // Reset mid-packet
    @(negedge clk);
    start = 1'b1; mode = 1'b1; len = LEN_W'(64); data = {$urandom, $urandom};
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 100 && cnt < 5; cyc++) begin
      if (bit_valid) cnt++;
      @(negedge clk);
    end
    check("midrst_bits_sent", cnt, 5);
    rst_b = 1'b0;
    #1;
    check("midrst_outputs", {ready, bit_valid, bit_out, done}, 4'b1000);
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
    check("midrst_crc_q", crc_q, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst_b = 1'b1;
    send("token_after_rst", 1'b0, 11, 64'd0, 0, 0);
    check("tar_crc_bits", {got_q[11], got_q[12], got_q[13], got_q[14], got_q[15]}, 5'b01000);

    // Length clamp
    send("clamp", 1'b1, MAX_BITS + 5, {$urandom, $urandom}, 0, 0);
    check("clamp_total", got_q.size(), MAX_BITS + 16);

    // Randomized packets
    for (int p = 0; p < 6; p++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      send($sformatf("rand%0d", p), m, $urandom_range(0, MAX_BITS), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 0);
`ifdef USB_CRC_SERIALIZER_CRCQ_EN
      check($sformatf("rand%0d_crc_q", p), crc_q, 64'(exp_crc));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_crc_serializer.md
USB_CRC_SERIALIZER -- requirements
Module: usb_crc_serializer

Interface
REQ-001 Parameter MAX_BITS, default 64, maximum payload bits per packet (range 8..1024).
REQ-002 Parameter LEN_W, default $clog2(MAX_BITS+1), width of the len port.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request to load a packet; accepted only when ready=1.
REQ-006 Port mode  input  1  0 = CRC5 (token), 1 = CRC16 (data); sampled at accept.
REQ-007 Port len  input  LEN_W  number of payload bits; sampled at accept.
REQ-008 Port data  input  MAX_BITS  payload, data[0] transmitted first; sampled at accept.
REQ-009 Port ready  output  1  block idle, can accept start.
REQ-010 Port bit_out  output  1  serial bit to the bit stuffer; meaningful only when bit_valid=1.
REQ-011 Port bit_valid  output  1  bit_out holds a valid bit.
REQ-012 Port out_ready  input  1  downstream accepts bit_out this cycle (stall when 0).
REQ-013 Port done  output  1  one-cycle pulse after the last CRC bit is accepted.

Function
REQ-014 States: IDLE, DATA, CRC, DONE; the encoding is free.
REQ-015 IDLE: ready=1, bit_valid=0. start=1 latches data, len and mode, and loads the CRC register with all ones (5 or 16 bits). Next state is DATA, or CRC when len=0.
REQ-016 A len value greater than MAX_BITS is clamped to MAX_BITS.
REQ-017 The first bit_valid=1 occurs in the cycle after accept, so latency is 1 cycle.
REQ-018 Handshake: a bit is consumed only in a cycle with bit_valid=1 and out_ready=1. Otherwise bit_out, the CRC register and the bit index hold.
REQ-019 DATA: bit_out = data[idx], with idx starting at 0. Each consumed bit updates the CRC with fb = crc[MSB] ^ bit_out and crc = {crc[MSB-1:0],0} ^ (fb ? poly : 0).
REQ-020 CRC5 uses poly 5'b00101. CRC16 uses poly 16'h8005.
REQ-021 When the bit at idx = len-1 is consumed, the state moves to CRC and the CRC register freezes.
REQ-022 CRC: bit_out = ~crc[k], for k running from MSB down to 0 (5 or 16 bits). After bit 0 is consumed, the state moves to DONE.
REQ-023 DONE: done=1 and bit_valid=0 for exactly one cycle, then IDLE. ready=0 during DONE.
REQ-024 start while not IDLE is ignored, with no effect on the packet in flight.
REQ-025 ready, bit_valid and done are driven from registered state only; they have no combinational path from start or out_ready.

Reset
REQ-026 rst_b=0 forces, asynchronously, state IDLE, ready=1, bit_valid=0, bit_out=0, done=0, CRC register all ones and index 0.
REQ-027 Reset mid-packet aborts the packet. No done pulse is produced, and the next start after release begins a fresh packet.

Configuration
REQ-028 Macro USB_CRC_SERIALIZER_CRCQ_EN, when defined, adds output port crc_q [15:0], updated in DONE. It holds the complemented CRC, zero-extended for CRC5, and keeps that value until the next DONE or reset. Reset value is 0.
REQ-029 Without USB_CRC_SERIALIZER_CRCQ_EN, the crc_q port and its register do not exist. All other behaviour is identical.

Verification
REQ-030 Token: mode=0, len=11, data=0, out_ready=1. The bench sees 11 zeros followed by CRC bits 0,1,0,0,0, then done on the next cycle.
REQ-031 Empty data packet: mode=1, len=0. The bench sees 16 zero bits (CRC16 = 16'h0000 after complement), then done; ready returns 1 after DONE.
REQ-032 Stall: mode=1, len=8, data=8'hA5, with out_ready toggled randomly. The bit sequence must match the out_ready=1 run and the software CRC16 model. bit_out is stable while stalled.
REQ-033 Busy start: pulse start with a different data value while in DATA. The in-flight stream is unchanged and no second packet is emitted.
REQ-034 Reset: assert rst_b=0 after 5 bits of a len=64 packet. All outputs reach their reset values immediately. After release, a mode=0, len=11 packet passes REQ-030.
REQ-035 Clamp and macro: len=MAX_BITS+5 emits exactly MAX_BITS data bits. With USB_CRC_SERIALIZER_CRCQ_EN defined, crc_q equals 16'h0008 after the REQ-030 packet.
